// File: rtl/joy_dir_filter.sv
// Joystick direction conditioner: per-player sync, optional debounce and 90-degree
// rotation, then 4-way last-pressed / 4-way first-held / 8-way cancel / raw restriction.
module joy_dir_filter #(
  parameter int PLAYERS   = 2,
  parameter int DB_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   rotate,
  input  logic [4*PLAYERS-1:0]   indir,
  output logic [4*PLAYERS-1:0]   outdir,
  output logic [PLAYERS-1:0]     dir_chg
);

  localparam int NB = 4 * PLAYERS;

  localparam logic [1:0] MODE_LAST  = 2'd0;
  localparam logic [1:0] MODE_FIRST = 2'd1;
  localparam logic [1:0] MODE_8WAY  = 2'd2;
  localparam logic [1:0] MODE_RAW   = 2'd3;

  // Bit order within a group is {up, down, left, right}; up has highest priority.
  function automatic logic [3:0] pick_dir(input logic [3:0] v);
    logic [3:0] r;
    r = 4'b0000;
    if (v[3])      r = 4'b1000;
    else if (v[2]) r = 4'b0100;
    else if (v[1]) r = 4'b0010;
    else if (v[0]) r = 4'b0001;
    return r;
  endfunction

  function automatic logic [3:0] rot_dir(input logic [3:0] v);
    return {v[1], v[0], v[2], v[3]};
  endfunction

  function automatic logic [3:0] cancel_dir(input logic [3:0] v);
    logic [3:0] r;
    r = v;
    if (v[3] && v[2]) r[3:2] = 2'b00;
    if (v[1] && v[0]) r[1:0] = 2'b00;
    return r;
  endfunction

  logic [NB-1:0]      sync1_q, sync2_q;
  logic [NB-1:0]      rot_s;
  logic [NB-1:0]      db;
  logic [NB-1:0]      db_prev_q;
  logic [NB-1:0]      mask_q, mask_d;
  logic [NB-1:0]      outdir_q, out_d;
  logic [PLAYERS-1:0] dir_chg_q, chg_d;
  logic [1:0]         mode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= indir;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    rot_s = sync2_q;
    if (rotate) begin
      for (int p = 0; p < PLAYERS; p++) begin
        rot_s[4*p +: 4] = rot_dir(sync2_q[4*p +: 4]);
      end
    end
  end

  // Debounce: a bit flips only after DB_CYCLES consecutive cycles of disagreement.
  if (DB_CYCLES > 0) begin : g_db
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt_q [NB];
    logic [NB-1:0] db_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        db_q <= '0;
        for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
      end else begin
        for (int b = 0; b < NB; b++) begin
          if (rot_s[b] == db_q[b]) begin
            cnt_q[b] <= '0;
          end else if (cnt_q[b] == CNT_LAST) begin
            db_q[b]  <= ~db_q[b];
            cnt_q[b] <= '0;
          end else begin
            cnt_q[b] <= cnt_q[b] + CW'(1);
          end
        end
      end
    end

    assign db = db_q;
  end else begin : g_nodb
    assign db = rot_s;
  end

  // Masks and outputs are computed from the same-cycle next mask so arbitration adds no latency.
  always_comb begin
    logic [3:0] db_g, rise_g, mq_g, md_g;
    logic       mode_chg;
    mask_d   = '0;
    out_d    = '0;
    chg_d    = '0;
    db_g     = 4'b0000;
    rise_g   = 4'b0000;
    mq_g     = 4'b0000;
    md_g     = 4'b0000;
    mode_chg = (mode != mode_q);
    for (int p = 0; p < PLAYERS; p++) begin
      db_g   = db[4*p +: 4];
      rise_g = db_g & ~db_prev_q[4*p +: 4];
      mq_g   = mask_q[4*p +: 4];
      md_g   = 4'b0000;
      case (mode)
        MODE_LAST: begin
          if (mode_chg)               md_g = 4'b0000;
          else if (rise_g != 4'b0000) md_g = pick_dir(rise_g);
          else if ((db_g & mq_g) == 4'b0000) md_g = pick_dir(db_g);
          else                        md_g = mq_g;
          out_d[4*p +: 4] = db_g & md_g;
        end
        MODE_FIRST: begin
          if (mode_chg)               md_g = 4'b0000;
          else if ((db_g & mq_g) == 4'b0000)
            md_g = (rise_g != 4'b0000) ? pick_dir(rise_g) : pick_dir(db_g);
          else                        md_g = mq_g;
          out_d[4*p +: 4] = db_g & md_g;
        end
        MODE_8WAY: out_d[4*p +: 4] = cancel_dir(db_g);
        MODE_RAW:  out_d[4*p +: 4] = db_g;
        default:   out_d[4*p +: 4] = db_g;
      endcase
      mask_d[4*p +: 4] = md_g;
      chg_d[p]         = (out_d[4*p +: 4] != outdir_q[4*p +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_prev_q <= '0;
      mask_q    <= '0;
      outdir_q  <= '0;
      dir_chg_q <= '0;
      mode_q    <= MODE_LAST;
    end else begin
      db_prev_q <= db;
      mask_q    <= mask_d;
      outdir_q  <= out_d;
      dir_chg_q <= chg_d;
      mode_q    <= mode;
    end
  end

  assign outdir  = outdir_q;
  assign dir_chg = dir_chg_q;

endmodule

// File: tb/tb_joy_dir_filter.sv
// Directed bench for joy_dir_filter: one instance without debounce, one with DB_CYCLES=8.
module tb_joy_dir_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       rotate;
  logic [7:0] indir0, indir8;
  logic [7:0] out0, out8;
  logic [1:0] chg0, chg8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  joy_dir_filter #(.PLAYERS(2), .DB_CYCLES(0)) u_db0 (
    .clk(clk), .reset(reset), .mode(mode), .rotate(rotate),
    .indir(indir0), .outdir(out0), .dir_chg(chg0)
  );

  joy_dir_filter #(.PLAYERS(2), .DB_CYCLES(8)) u_db8 (
    .clk(clk), .reset(reset), .mode(mode), .rotate(rotate),
    .indir(indir8), .outdir(out8), .dir_chg(chg8)
  );

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    mode   = 2'd0;
    rotate = 1'b0;
    indir0 = 8'h00;
    indir8 = 8'h00;
    tick(3);
    chk("rst_out0", out0, 8'h00);
    chk("rst_chg0", {6'd0, chg0}, 8'h00);
    chk("rst_out8", out8, 8'h00);
    reset = 1'b0;
    tick(1);

    // Latency and reset mid-hold
    indir0 = 8'h08;
    tick(2);
    chk("lat_early", out0, 8'h00);
    tick(1);
    chk("lat_out", out0, 8'h08);
    chk("lat_chg", {6'd0, chg0}, 8'h01);
    tick(1);
    chk("lat_chg_end", {6'd0, chg0}, 8'h00);
    reset = 1'b1;
    tick(1);
    chk("rst_hold_out", out0, 8'h00);
    chk("rst_hold_chg", {6'd0, chg0}, 8'h00);
    reset  = 1'b0;
    indir0 = 8'h00;
    tick(5);
    chk("post_rst_idle", out0, 8'h00);

    // Mode 0 last-pressed with fallback
    indir0 = 8'h08;
    tick(3);
    chk("m0_up", out0, 8'h08);
    chk("m0_up_chg", {6'd0, chg0}, 8'h01);
    indir0 = 8'h09;
    tick(2);
    chk("m0_right_early", out0, 8'h08);
    tick(1);
    chk("m0_right", out0, 8'h01);
    chk("m0_right_chg", {6'd0, chg0}, 8'h01);
    tick(1);
    chk("m0_right_chg_end", {6'd0, chg0}, 8'h00);
    indir0 = 8'h08;
    tick(2);
    chk("m0_fall_early", out0, 8'h01);
    tick(1);
    chk("m0_fallback", out0, 8'h08);
    chk("m0_fallback_chg", {6'd0, chg0}, 8'h01);
    indir0 = 8'h00;
    tick(4);
    chk("m0_release", out0, 8'h00);
    indir0 = 8'h06;
    tick(3);
    chk("m0_simul", out0, 8'h04);
    indir0 = 8'h00;
    tick(4);

    // Mode 1 first-held
    mode = 2'd1;
    tick(2);
    indir0 = 8'h02;
    tick(3);
    chk("m1_left", out0, 8'h02);
    indir0 = 8'h0A;
    tick(4);
    chk("m1_no_steal", out0, 8'h02);
    indir0 = 8'h08;
    tick(2);
    chk("m1_still_left", out0, 8'h02);
    tick(1);
    chk("m1_up_after", out0, 8'h08);
    indir0 = 8'h00;
    tick(4);

    // Mode 2 opposite cancel, then change back to mode 0
    mode = 2'd2;
    tick(2);
    indir0 = 8'h0D;
    tick(3);
    chk("m2_cancel_ud", out0, 8'h01);
    indir0 = 8'h0A;
    tick(3);
    chk("m2_diag", out0, 8'h0A);
    mode = 2'd0;
    tick(1);
    chk("mchg_clear", out0, 8'h00);
    chk("mchg_clear_chg", {6'd0, chg0}, 8'h01);
    tick(1);
    chk("mchg_reselect", out0, 8'h08);
    indir0 = 8'h00;
    tick(4);

    // Rotation on player 1 only
    rotate = 1'b1;
    indir0 = 8'h20;
    tick(3);
    chk("rot_out", out0, 8'h80);
    chk("rot_chg", {6'd0, chg0}, 8'h02);
    indir0 = 8'h00;
    tick(6);
    rotate = 1'b0;
    tick(2);
    chk("rot_idle", out0, 8'h00);

    // Debounce: a 7-cycle glitch must not propagate
    indir8 = 8'h02;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      chk("db_glitch_hi", out8, 8'h00);
    end
    indir8 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("db_glitch_lo", out8, 8'h00);
    end
    indir8 = 8'h02;
    tick(10);
    chk("db_hold_early", out8, 8'h00);
    tick(1);
    chk("db_hold_out", out8, 8'h02);
    chk("db_hold_chg", {6'd0, chg8}, 8'h01);
    indir8 = 8'h00;
    tick(14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
